hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/hazard_perf_cnt.sv | 22 ++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: register index width, hazard FSM states, load-use helper
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_t;

  // A load in EX whose destination feeds either ID source; r0 never creates a dependency.
  function automatic logic is_load_use(input logic             memread,
                                       input logic [REG_W-1:0] ex_rt,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt);
    return memread && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - wrapping 32-bit stall and flush cycle counters
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Count cycles in which the PC was held and cycles in which a flush was applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control (load-use, branch flush, memory stall/timeout); HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             id_ex_memread,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam logic [16:0] WAIT_LIMIT = 17'(MAX_WAIT - 1);

  hz_state_t   state_q, state_d;
  logic        br_pend_q, br_pend_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic flush_req;
  logic wait_limit;

  assign load_use   = is_load_use(id_ex_memread, id_ex_rt, if_id_rs, if_id_rt);
  assign flush_req  = branch_taken | br_pend_q;
  // The incremented count reaching MAX_WAIT-1 ends the tolerated wait.
  assign wait_limit = (17'(wait_cnt_q) + 17'd1) >= WAIT_LIMIT;

  // State, pending-branch and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      br_pend_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      br_pend_q  <= br_pend_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state: track memory stall length, remember a branch that arrived during a stall.
  always_comb begin
    state_d    = state_q;
    br_pend_d  = br_pend_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (mem_busy) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          if (wait_limit) state_d = TIMEOUT;
        end
      end
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = RUN;
    endcase
    if (state_q != TIMEOUT) begin
      if (mem_busy && branch_taken) br_pend_d = 1'b1;
      else if (!mem_busy && flush_req) br_pend_d = 1'b0;
    end
  end

  // Outputs by priority: timeout, memory stall, flush, load-use bubble, normal.
  // While in reset the pipeline runs freely regardless of mem_busy.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    timeout_err  = 1'b0;
    if (!rst_n) begin
      pc_write = 1'b1;
    end else if (state_q == TIMEOUT) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      timeout_err  = 1'b1;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (flush_req) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (~pc_write),
    .flush     (if_id_flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush, id_ex_flush, timeout_err}
  localparam logic [7:0] NORM  = 8'b1111_0000;
  localparam logic [7:0] STALL = 8'b0000_0000;
  localparam logic [7:0] FLUSH = 8'b1111_0110;
  localparam logic [7:0] LU    = 8'b0011_1000;
  localparam logic [7:0] TMO   = 8'b0000_0001;

  typedef struct {
    string       name;
    logic [7:0]  vec;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
  logic       id_ex_memread = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       id_ex_bubble, if_id_flush, id_ex_flush, timeout_err;
  logic [7:0] act;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [31:0] m_stall = '0, m_flush = '0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .id_ex_rt      (id_ex_rt),
    .id_ex_memread (id_ex_memread),
    .branch_taken  (branch_taken),
    .mem_busy      (mem_busy),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_write   (id_ex_write),
    .ex_mem_write  (ex_mem_write),
    .id_ex_bubble  (id_ex_bubble),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .timeout_err   (timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  assign act = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                id_ex_bubble, if_id_flush, id_ex_flush, timeout_err};

  // Apply one cycle of inputs and queue the hand-computed response.
  task automatic step(input string name, input logic rst, input logic busy, input logic br,
                      input logic rd, input logic [4:0] exrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [7:0] exp_vec);
    exp_t e;
    @(negedge clk);
    rst_n = rst; mem_busy = busy; branch_taken = br;
    id_ex_memread = rd; id_ex_rt = exrt; if_id_rs = rs; if_id_rt = rt;
    e.name = name;
    e.vec  = exp_vec;
    if (!rst) begin
      m_stall = '0;
      m_flush = '0;
    end
    e.st = m_stall;
    e.fl = m_flush;
    exp_q.push_back(e);
    if (rst) begin
      if (!exp_vec[7]) m_stall = m_stall + 32'd1;
      if (exp_vec[2])  m_flush = m_flush + 32'd1;
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e.vec) begin
          failures++;
          $display("FAIL %s: outputs=%b expected=%b", e.name, act, e.vec);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== e.st || flush_cnt !== e.fl) begin
          failures++;
          $display("FAIL %s_cnt: stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.name, stall_cnt, flush_cnt, e.st, e.fl);
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    //    name          rst busy br rd exrt rs  rt  expected
    step("reset",       0,  1,  0, 0, 0,   0,  0,  NORM);
    step("normal",      1,  0,  0, 0, 0,   0,  0,  NORM);
    step("lu_rs",       1,  0,  0, 1, 5,   5,  2,  LU);
    step("lu_release",  1,  0,  0, 0, 5,   5,  2,  NORM);
    step("lu_rt",       1,  0,  0, 1, 7,   3,  7,  LU);
    step("lu_r0",       1,  0,  0, 1, 0,   0,  0,  NORM);
    step("lu_nomatch",  1,  0,  0, 1, 5,   6,  4,  NORM);
    step("br_lu",       1,  0,  1, 1, 5,   5,  0,  FLUSH);
    step("br_after",    1,  0,  0, 0, 0,   0,  0,  NORM);
    step("bp_busy1",    1,  1,  1, 0, 0,   0,  0,  STALL);
    step("bp_busy2",    1,  1,  0, 0, 0,   0,  0,  STALL);
    step("bp_busy3",    1,  1,  0, 0, 0,   0,  0,  STALL);
    step("bp_flush",    1,  0,  0, 1, 5,   5,  0,  FLUSH);
    step("bp_cleared",  1,  0,  0, 0, 0,   0,  0,  NORM);
    step("busy_lu",     1,  1,  0, 1, 9,   9,  0,  STALL);
    step("lu_post",     1,  0,  0, 1, 9,   9,  0,  LU);
    step("idle",        1,  0,  0, 0, 0,   0,  0,  NORM);
    step("to_b1",       1,  1,  0, 0, 0,   0,  0,  STALL);
    step("to_b2",       1,  1,  0, 0, 0,   0,  0,  STALL);
    step("to_b3",       1,  1,  0, 0, 0,   0,  0,  STALL);
    step("to_b4",       1,  1,  0, 0, 0,   0,  0,  STALL);
    step("to_err",      1,  0,  0, 0, 0,   0,  0,  TMO);
    step("to_br",       1,  0,  1, 0, 0,   0,  0,  TMO);
    step("to_lu",       1,  0,  0, 1, 5,   5,  0,  TMO);
    step("to_rst",      0,  1,  0, 0, 0,   0,  0,  NORM);
    step("to_post_rst", 1,  0,  0, 0, 0,   0,  0,  NORM);
    step("mw_busy1",    1,  1,  1, 0, 0,   0,  0,  STALL);
    step("mw_busy2",    1,  1,  0, 0, 0,   0,  0,  STALL);
    step("mw_rst",      0,  1,  0, 0, 0,   0,  0,  NORM);
    step("mw_post_rst", 1,  0,  0, 0, 0,   0,  0,  NORM);
    step("mw_busy_new", 1,  1,  0, 0, 0,   0,  0,  STALL);
    step("mw_end",      1,  0,  0, 0, 0,   0,  0,  NORM);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
